// File: rtl/vga_timing_gen_pkg.sv
// Shared 640x480@60 timing constants for the timing generator, the pixel
// source and the output stage.
package vga_timing_gen_pkg;

  localparam int CNT_W = 10;

  localparam int VGA_H_ACTIVE = 640;
  localparam int VGA_H_FP     = 16;
  localparam int VGA_H_SYNC   = 96;
  localparam int VGA_H_BP     = 48;
  localparam int VGA_H_TOTAL  = VGA_H_ACTIVE + VGA_H_FP + VGA_H_SYNC + VGA_H_BP;

  localparam int VGA_V_ACTIVE = 480;
  localparam int VGA_V_FP     = 10;
  localparam int VGA_V_SYNC   = 2;
  localparam int VGA_V_BP     = 33;
  localparam int VGA_V_TOTAL  = VGA_V_ACTIVE + VGA_V_FP + VGA_V_SYNC + VGA_V_BP;

  // 0 = active-low syncs (VGA standard)
  localparam logic VGA_SYNC_POL = 1'b0;

endpackage

// File: rtl/vga_timing_gen_axis_counter.sv
// One timing axis: wrapping position counter with enable, terminal-count
// flag and combinational sync/active window decode of the current count.
module vga_axis_counter
  import vga_timing_gen_pkg::*;
#(
  parameter int W      = CNT_W,
  parameter int ACTIVE = VGA_H_ACTIVE,
  parameter int FP     = VGA_H_FP,
  parameter int SYNC   = VGA_H_SYNC,
  parameter int BP     = VGA_H_BP
) (
  input  logic         clk,
  input  logic         rstn,
  input  logic         en,
  output logic [W-1:0] cnt,
  output logic         tc,
  output logic         sync_win,
  output logic         active_win
);

  localparam int TOTAL = ACTIVE + FP + SYNC + BP;

  localparam logic [W-1:0] LAST     = W'(TOTAL - 1);
  localparam logic [W-1:0] ACT_END  = W'(ACTIVE);
  localparam logic [W-1:0] SYNC_BEG = W'(ACTIVE + FP);
  localparam logic [W-1:0] SYNC_LST = W'(ACTIVE + FP + SYNC - 1);

  // position register: reset wins, otherwise advance and wrap on terminal count
  always_ff @(posedge clk) begin
    if (!rstn)
      cnt <= '0;
    else if (en)
      cnt <= tc ? '0 : cnt + W'(1);
  end

  assign tc         = (cnt == LAST);
  assign active_win = (cnt < ACT_END);
  assign sync_win   = (cnt >= SYNC_BEG) && (cnt <= SYNC_LST);

endmodule

// File: rtl/vga_timing_gen.sv
// Free-running VGA timing generator. Two axis counters (V advances on the H
// terminal count); all outputs are registered together so they describe the
// counter position of the previous cycle.
module vga_timing_gen
  import vga_timing_gen_pkg::*;
#(
  parameter int   H_ACTIVE = VGA_H_ACTIVE,
  parameter int   H_FP     = VGA_H_FP,
  parameter int   H_SYNC   = VGA_H_SYNC,
  parameter int   H_BP     = VGA_H_BP,
  parameter int   V_ACTIVE = VGA_V_ACTIVE,
  parameter int   V_FP     = VGA_V_FP,
  parameter int   V_SYNC   = VGA_V_SYNC,
  parameter int   V_BP     = VGA_V_BP,
  parameter logic SYNC_POL = VGA_SYNC_POL
) (
  input  logic             i_clk,
  input  logic             i_rstn,
  output logic             o_vsync,
  output logic             o_hsync,
  output logic             o_active,
  output logic [CNT_W-1:0] o_counterX,
  output logic [CNT_W-1:0] o_counterY
);

  logic [CNT_W-1:0] hcnt, vcnt;
  logic             h_tc, h_sync, h_act;
  logic             v_sync, v_act;

  vga_axis_counter #(
    .W(CNT_W), .ACTIVE(H_ACTIVE), .FP(H_FP), .SYNC(H_SYNC), .BP(H_BP)
  ) u_h (
    .clk(i_clk), .rstn(i_rstn), .en(1'b1),
    .cnt(hcnt), .tc(h_tc), .sync_win(h_sync), .active_win(h_act)
  );

  // frame wrap coincides with the line wrap, so the V terminal count is not needed here
  vga_axis_counter #(
    .W(CNT_W), .ACTIVE(V_ACTIVE), .FP(V_FP), .SYNC(V_SYNC), .BP(V_BP)
  ) u_v (
    .clk(i_clk), .rstn(i_rstn), .en(h_tc),
    .cnt(vcnt), .tc(), .sync_win(v_sync), .active_win(v_act)
  );

  // output register: one-cycle aligned snapshot of position, syncs and data enable
  always_ff @(posedge i_clk) begin
    if (!i_rstn) begin
      o_counterX <= '0;
      o_counterY <= '0;
      o_active   <= 1'b0;
      o_hsync    <= ~SYNC_POL;
      o_vsync    <= ~SYNC_POL;
    end else begin
      o_counterX <= hcnt;
      o_counterY <= vcnt;
      o_active   <= h_act & v_act;
      o_hsync    <= h_sync ? SYNC_POL : ~SYNC_POL;
      o_vsync    <= v_sync ? SYNC_POL : ~SYNC_POL;
    end
  end

endmodule

// File: tb/tb_vga_timing_gen.sv
// Bench for vga_timing_gen: full-size 640x480 instance for reset, line and
// hsync checks; a shrunken, active-high-sync instance (25x13) so whole frames,
// vsync and frame wrap are covered in a few hundred clocks. Both are
// cross-checked every cycle against independent position models.
module tb_vga_timing_gen;

  logic       clk = 1'b0;
  logic       rst_n, rst_s;
  logic       vs, hs, act;
  logic [9:0] cx, cy;
  logic       s_vs, s_hs, s_act;
  logic [9:0] s_cx, s_cy;

  int total = 0;
  int bad   = 0;
  bit mchk  = 1'b0;

  always #20 clk = ~clk;  // 25 MHz

  vga_timing_gen dut (
    .i_clk(clk), .i_rstn(rst_n), .o_vsync(vs), .o_hsync(hs), .o_active(act),
    .o_counterX(cx), .o_counterY(cy)
  );

  vga_timing_gen #(
    .H_ACTIVE(16), .H_FP(2), .H_SYNC(4), .H_BP(3),
    .V_ACTIVE(6), .V_FP(2), .V_SYNC(2), .V_BP(3), .SYNC_POL(1'b1)
  ) dut_s (
    .i_clk(clk), .i_rstn(rst_s), .o_vsync(s_vs), .o_hsync(s_hs), .o_active(s_act),
    .o_counterX(s_cx), .o_counterY(s_cy)
  );

  task automatic chk(input string tag, input int got, input int exp);
    total++;
    if (got != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
    end
  endtask

  // reference models: 800x525 (syncs low at X 656..751 / Y 490..491) and 25x13 (syncs high at X 18..21 / Y 8..9)
  int mx, my, ex, ey, sx, sy, esx, esy;
  bit eact, ehs, evs, esact, eshs, esvs;

  always @(posedge clk) begin
    if (!rst_n) begin
      mx <= 0; my <= 0; ex <= 0; ey <= 0; eact <= 0; ehs <= 1; evs <= 1;
    end else begin
      ex <= mx; ey <= my;
      eact <= (mx < 640) && (my < 480);
      ehs  <= !(mx >= 656 && mx <= 751);
      evs  <= !(my == 490 || my == 491);
      mx   <= (mx == 799) ? 0 : mx + 1;
      if (mx == 799) my <= (my == 524) ? 0 : my + 1;
    end
    if (!rst_s) begin
      sx <= 0; sy <= 0; esx <= 0; esy <= 0; esact <= 0; eshs <= 0; esvs <= 0;
    end else begin
      esx <= sx; esy <= sy;
      esact <= (sx < 16) && (sy < 6);
      eshs  <= (sx >= 18 && sx <= 21);
      esvs  <= (sy == 8 || sy == 9);
      sx    <= (sx == 24) ? 0 : sx + 1;
      if (sx == 24) sy <= (sy == 12) ? 0 : sy + 1;
    end
  end

  // per-cycle cross-check of both instances
  always @(negedge clk) begin
    if (mchk) begin
      chk("m_x", cx, ex);     chk("m_y", cy, ey);   chk("m_act", act, eact);
      chk("m_hs", hs, ehs);   chk("m_vs", vs, evs);
      chk("s_x", s_cx, esx);  chk("s_y", s_cy, esy); chk("s_act", s_act, esact);
      chk("s_hs", s_hs, eshs); chk("s_vs", s_vs, esvs);
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int hlow, hfirst, acnt, n;
    int svs, shs, sact, lx, ly;
    rst_n = 1'b0;
    rst_s = 1'b0;

    // reset held over three rising edges (>100 ns)
    repeat (3) @(negedge clk);
    chk("rst_x", cx, 0);   chk("rst_y", cy, 0);  chk("rst_act", act, 0);
    chk("rst_hs", hs, 1);  chk("rst_vs", vs, 1);
    chk("rst_s_hs", s_hs, 0); chk("rst_s_vs", s_vs, 0);
    rst_n = 1'b1;
    rst_s = 1'b1;

    @(negedge clk);
    chk("first_x", cx, 0); chk("first_y", cy, 0); chk("first_act", act, 1);
    chk("first_hs", hs, 1); chk("first_vs", vs, 1);
    mchk = 1'b1;

    // two full lines: active/hsync window counts and positions
    for (int line = 0; line < 2; line++) begin
      hlow = 0; hfirst = -1; acnt = 0;
      for (int i = 0; i < 800; i++) begin
        if (i == 639) chk("act_639", act, 1);
        if (i == 640) chk("act_640", act, 0);
        if (!hs) begin
          if (hfirst < 0) hfirst = cx;
          hlow++;
        end
        if (act) acnt++;
        @(negedge clk);
      end
      chk("hs_low_cnt", hlow, 96);
      chk("hs_first_x", hfirst, 656);
      chk("act_cnt", acnt, 640);
      chk("line_wrap_x", cx, 0);
      chk("line_wrap_y", cy, line + 1);
    end

    // mid-line reset at X=300
    n = 0;
    while (cx != 300 && n < 900) begin @(negedge clk); n++; end
    chk("wait_x300", cx, 300);
    rst_n = 1'b0;
    @(negedge clk);
    chk("mrst_x", cx, 0);  chk("mrst_y", cy, 0); chk("mrst_act", act, 0);
    chk("mrst_hs", hs, 1); chk("mrst_vs", vs, 1);
    rst_n = 1'b1;
    @(negedge clk);
    chk("rel_x", cx, 0); chk("rel_y", cy, 0); chk("rel_act", act, 1);
    @(negedge clk);
    chk("rel_x1", cx, 1);

    // small instance: reset mid-frame at (10,4), then one full frame of 325 clocks
    n = 0;
    while (!(s_cx == 10 && s_cy == 4) && n < 400) begin @(negedge clk); n++; end
    chk("wait_s_x", s_cx, 10);
    chk("wait_s_y", s_cy, 4);
    rst_s = 1'b0;
    @(negedge clk);
    chk("s_mrst_x", s_cx, 0); chk("s_mrst_y", s_cy, 0); chk("s_mrst_act", s_act, 0);
    chk("s_mrst_hs", s_hs, 0); chk("s_mrst_vs", s_vs, 0);
    rst_s = 1'b1;
    @(negedge clk);
    chk("s_rel_act", s_act, 1);
    svs = 0; shs = 0; sact = 0; lx = -1; ly = -1;
    for (int i = 0; i < 325; i++) begin
      if (s_vs) svs++;
      if (s_hs) shs++;
      if (s_act) sact++;
      if (i == 324) begin lx = s_cx; ly = s_cy; end
      @(negedge clk);
    end
    chk("s_vs_cnt", svs, 50);
    chk("s_hs_cnt", shs, 52);
    chk("s_act_cnt", sact, 96);
    chk("s_last_x", lx, 24);
    chk("s_last_y", ly, 12);
    chk("s_wrap_x", s_cx, 0);
    chk("s_wrap_y", s_cy, 0);

    // let the small instance run two more frames under the per-cycle check
    repeat (650) @(negedge clk);
    mchk = 1'b0;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
